// File: rtl/fir_convolve_engine.sv
`default_nettype none
// ============================================================================
//  Module   : fir_convolve_engine
//  Purpose  : Long FIR convolution engine. Each accepted audio sample goes into
//             a TAPS-deep circular history. LANES parallel MACs then sweep the
//             impulse response, which is read block by block from an external
//             coefficient memory. The lane sums are reduced and the result is
//             presented through a valid/ready handshake.
//  Options  : FIR_CONVOLVE_SAT_EN - saturate the result to OUT_W and raise
//             sat_flag_out when clipped (default: truncate, flag tied 0).
//  Revision : 1.0 - initial release
// ============================================================================
module fir_convolve_engine #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 24000,
  parameter int LANES     = 8,
  parameter int COEF_LAT  = 2,
  parameter int ACC_W     = 48,
  parameter int OUT_W     = 24,
  parameter int OUT_SHIFT = 0
) (
  input  logic                                                 audio_clk,
  input  logic                                                 rst_n_in,
  input  logic [DATA_W-1:0]                                    sample_in,
  input  logic                                                 sample_valid_in,
  output logic                                                 sample_ready_out,
  input  logic                                                 clear_in,
  output logic [((TAPS/LANES) > 1 ? $clog2(TAPS/LANES) : 1)-1:0] coef_block_idx_out,
  input  logic [LANES-1:0][COEF_W-1:0]                         coef_vals_in,
  output logic [OUT_W-1:0]                                     result_out,
  output logic                                                 result_valid_out,
  input  logic                                                 result_ready_in,
  output logic                                                 busy_out,
  output logic                                                 sat_flag_out
);

  localparam int NBLK    = TAPS / LANES;
  localparam int BLK_W   = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int PTR_W   = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int FILL_W  = $clog2(TAPS + 1);
  localparam int PROD_W  = DATA_W + COEF_W;
  localparam int CNT_MAX = (COEF_LAT > LANES) ? COEF_LAT : LANES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_MAC    = 3'd2,
    S_DRAIN  = 3'd3,
    S_REDUCE = 3'd4,
    S_OUTPUT = 3'd5
  } state_t;

  state_t                    state_q;
  logic [BLK_W-1:0]          blk_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [PTR_W-1:0]          wr_ptr_q;
  logic [FILL_W-1:0]         fill_q;
  logic [FILL_W-1:0]         fill_d;
  logic                      clr_pend_q;
  logic signed [DATA_W-1:0]  sample_q;
  logic signed [ACC_W-1:0]   red_sum_q;
  logic [OUT_W-1:0]          result_q;
  logic                      sat_q;
  logic                      valid_q;
  logic                      ready_q;
  logic                      busy_q;
  logic [COEF_LAT-1:0]       v_pipe_q;
  logic signed [DATA_W-1:0]  hist_q [TAPS];
  logic signed [ACC_W-1:0]   w_acc_all [LANES];
  logic signed [ACC_W-1:0]   w_red_term;
  logic signed [ACC_W-1:0]   w_sum_final;
  logic signed [ACC_W-1:0]   w_shifted;
  logic [OUT_W-1:0]          w_res;
  logic                      w_sat;

  // Fill counts valid history entries and sticks at TAPS once the line is full
  assign fill_d = (fill_q == FILL_W'(TAPS)) ? fill_q : fill_q + FILL_W'(1);

  // History line: written once per sample; not reset because fill masks stale data
  always_ff @(posedge audio_clk) begin
    if (state_q == S_WRITE) hist_q[wr_ptr_q] <= sample_q;
  end

  // Issue-valid delay line, matching the coefficient memory read latency
  always_ff @(posedge audio_clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      v_pipe_q <= '0;
    end else begin
      v_pipe_q[0] <= (state_q == S_MAC);
      for (int s = 1; s < COEF_LAT; s++) v_pipe_q[s] <= v_pipe_q[s-1];
    end
  end

  generate
    for (genvar j = 0; j < LANES; j++) begin : g_lane
      logic [PTR_W:0]           w_tap;
      logic [PTR_W-1:0]         w_addr;
      logic                     w_live;
      logic signed [DATA_W-1:0] w_x;
      logic signed [DATA_W-1:0] x_pipe_q [COEF_LAT];
      logic signed [PROD_W-1:0] w_prod;
      logic signed [ACC_W-1:0]  acc_q;

      // Tap index i = block*LANES + j; history address wraps modulo TAPS
      assign w_tap  = (PTR_W+1)'(blk_q) * (PTR_W+1)'(LANES) + (PTR_W+1)'(j);
      assign w_addr = ({1'b0, wr_ptr_q} >= w_tap)
                    ? PTR_W'({1'b0, wr_ptr_q} - w_tap)
                    : PTR_W'({1'b0, wr_ptr_q} + (PTR_W+1)'(TAPS) - w_tap);
      assign w_live = (32'(w_tap) < 32'(fill_q));
      assign w_x    = w_live ? hist_q[w_addr] : '0;
      assign w_prod = PROD_W'(x_pipe_q[COEF_LAT-1]) * PROD_W'($signed(coef_vals_in[j]));
      assign w_acc_all[j] = acc_q;

      // Delay history reads to meet their coefficients, then accumulate
      always_ff @(posedge audio_clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
          for (int s = 0; s < COEF_LAT; s++) x_pipe_q[s] <= '0;
          acc_q <= '0;
        end else begin
          x_pipe_q[0] <= w_x;
          for (int s = 1; s < COEF_LAT; s++) x_pipe_q[s] <= x_pipe_q[s-1];
          if (state_q == S_OUTPUT && result_ready_in) acc_q <= '0;
          else if (v_pipe_q[COEF_LAT-1])              acc_q <= acc_q + ACC_W'(w_prod);
        end
      end
    end
  endgenerate

  // Select the lane accumulator being folded in during REDUCE
  always_comb begin
    w_red_term = '0;
    for (int r = 0; r < LANES; r++) begin
      if (cnt_q == CNT_W'(r)) w_red_term = w_acc_all[r];
    end
  end

  assign w_sum_final = red_sum_q + w_red_term;
  assign w_shifted   = w_sum_final >>> OUT_SHIFT;

`ifdef FIR_CONVOLVE_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Clamp the shifted sum into the signed OUT_W range
  always_comb begin
    w_res = w_shifted[OUT_W-1:0];
    w_sat = 1'b0;
    if (w_shifted > SAT_MAX) begin
      w_res = SAT_MAX[OUT_W-1:0];
      w_sat = 1'b1;
    end else if (w_shifted < SAT_MIN) begin
      w_res = SAT_MIN[OUT_W-1:0];
      w_sat = 1'b1;
    end
  end
`else
  // Plain truncation keeps the low OUT_W bits; upper bits are intentionally dropped
  logic w_unused_hi;
  assign w_unused_hi = &{1'b0, w_shifted};
  assign w_res       = w_shifted[OUT_W-1:0];
  assign w_sat       = 1'b0;
`endif

  // Control FSM with registered handshake and status outputs
  always_ff @(posedge audio_clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      blk_q      <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      clr_pend_q <= 1'b0;
      sample_q   <= '0;
      red_sum_q  <= '0;
      result_q   <= '0;
      sat_q      <= 1'b0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      if (clear_in && state_q != S_IDLE) clr_pend_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (clear_in) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
          end
          if (sample_valid_in) begin
            sample_q <= sample_in;
            state_q  <= S_WRITE;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        S_WRITE: begin
          fill_q  <= fill_d;
          blk_q   <= '0;
          state_q <= S_MAC;
        end
        S_MAC: begin
          if (blk_q == BLK_W'(NBLK - 1)) begin
            blk_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_DRAIN;
          end else begin
            blk_q <= blk_q + BLK_W'(1);
          end
        end
        S_DRAIN: begin
          if (cnt_q == CNT_W'(COEF_LAT - 1)) begin
            cnt_q   <= '0;
            state_q <= S_REDUCE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_REDUCE: begin
          red_sum_q <= w_sum_final;
          if (cnt_q == CNT_W'(LANES - 1)) begin
            cnt_q    <= '0;
            result_q <= w_res;
            sat_q    <= w_sat;
            valid_q  <= 1'b1;
            state_q  <= S_OUTPUT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_OUTPUT: begin
          if (result_ready_in) begin
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            red_sum_q  <= '0;
            state_q    <= S_IDLE;
            clr_pend_q <= 1'b0;
            if (clr_pend_q || clear_in) begin
              wr_ptr_q <= '0;
              fill_q   <= '0;
            end else begin
              wr_ptr_q <= (wr_ptr_q == PTR_W'(TAPS - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sample_ready_out   = ready_q;
  assign busy_out           = busy_q;
  assign result_valid_out   = valid_q;
  assign result_out         = result_q;
  assign sat_flag_out       = sat_q;
  assign coef_block_idx_out = blk_q;

endmodule
`default_nettype wire
